// File: rtl/vram_port_arbiter_pkg.sv
// Shared types and constants for the VRAM port arbiter and the blocks that
// build its display address and vblank inputs.
package vram_port_arbiter_pkg;

  localparam int VRAM_ADDR_W = 17;
  localparam int VRAM_DATA_W = 4;

  // 640x480 visible geometry; callers derive disp_addr and vblank from these.
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2
  } grant_e;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Bundle of the display, writer and RAM-side signals of the VRAM arbiter.
// The arbiter uses the slave modport; requesters and the RAM use master.
interface vram_port_arbiter_if
  import vram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = VRAM_ADDR_W,
  parameter int DATA_W  = VRAM_DATA_W,
  parameter int Q_DEPTH = 4
);
  localparam int LVL_W = level_width(Q_DEPTH);

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              vblank;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [LVL_W-1:0]  q_level;
  logic              busy;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, vblank, ram_rdata,
    output disp_valid, disp_data, wr_ready, ram_en, ram_we, ram_addr, ram_wdata,
           q_level, busy
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, vblank, ram_rdata,
    input  disp_valid, disp_data, wr_ready, ram_en, ram_we, ram_addr, ram_wdata,
           q_level, busy
  );

endinterface

// File: rtl/vram_port_arbiter_wr_fifo_sync.sv
// Small synchronous FIFO holding pending VRAM writes. The head is read
// straight from the storage array so a pop can be registered by the caller.
module wr_fifo_sync
  import vram_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = VRAM_ADDR_W + VRAM_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == (PTR_W + 1)'(DEPTH));
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares a single-port VRAM between display scanout (absolute priority) and
// a FIFO-buffered game-logic writer that drains whenever the port is free.
module vram_port_arbiter
  import vram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = VRAM_ADDR_W,
  parameter int DATA_W      = VRAM_DATA_W,
  parameter int Q_DEPTH     = 4,
  parameter int VBLANK_ONLY = 0
) (
  input  logic               clk,
  input  logic               reset,
  vram_port_arbiter_if.slave bus
);
  localparam int LVL_W   = level_width(Q_DEPTH);
  localparam int ENTRY_W = ADDR_W + DATA_W;

  grant_e             w_grant;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic [ENTRY_W-1:0] w_head;
  logic [LVL_W-1:0]   w_level;

  logic               r_ram_en;
  logic               r_ram_we;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic [DATA_W-1:0]  r_ram_wdata;
  logic               r_rd_s1;
  logic               r_rd_s2;

  always_comb begin
    w_grant = GNT_IDLE;
    if (bus.disp_req) begin
      w_grant = GNT_DISP;
    end else if (!w_fifo_empty && ((VBLANK_ONLY == 0) || bus.vblank)) begin
      w_grant = GNT_WR;
    end
  end

  assign w_push = bus.wr_valid && !w_fifo_full;
  assign w_pop  = (w_grant == GNT_WR);

  wr_fifo_sync #(
    .DEPTH (Q_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data ({bus.wr_addr, bus.wr_data}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full),
    .o_level     (w_level)
  );

  // Address/data hold their last value on idle cycles; only en/we drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rd_s1     <= 1'b0;
      r_rd_s2     <= 1'b0;
    end else begin
      r_rd_s1 <= (w_grant == GNT_DISP);
      r_rd_s2 <= r_rd_s1;
      case (w_grant)
        GNT_DISP: begin
          r_ram_en   <= 1'b1;
          r_ram_we   <= 1'b0;
          r_ram_addr <= bus.disp_addr;
        end
        GNT_WR: begin
          r_ram_en                  <= 1'b1;
          r_ram_we                  <= 1'b1;
          {r_ram_addr, r_ram_wdata} <= w_head;
        end
        default: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_en     = r_ram_en;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.disp_valid = r_rd_s2;
  // Gated so the display never sees stale RAM output outside a valid slot.
  assign bus.disp_data  = r_rd_s2 ? bus.ram_rdata : '0;
  assign bus.wr_ready   = !w_fifo_full;
  assign bus.q_level    = w_level;
  assign bus.busy       = (w_level != '0) || r_ram_we;

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one single-port synchronous video RAM between two requesters.
  - Display scanout: reads during the visible region, driven from the 640x480 timing generator's x/y/blank_n.
  - Game-logic writer: board/sprite updates.
- Display reads have absolute priority.
- Writes are buffered in a small FIFO and drained into RAM only when the display is not using the port. Optionally, draining is restricted to vertical blank for tear-free updates.
- Sits between the timing generator/pixel pipeline, the game FSM and the VRAM macro.

Parameters:
- ADDR_W, 17, RAM address width.
- DATA_W, 4, RAM data width (palette index).
- Q_DEPTH, 4, write FIFO depth; power of two, 2..16.
- VBLANK_ONLY, 0, 1 = writes drain only while vblank=1.

Ports:
- clk  in  1  pixel clock (25 MHz); one clock domain.
- reset  in  1  synchronous, active-high.
- disp_req  in  1  display read request, one per cycle (tie to blank_n).
- disp_addr  in  ADDR_W  display read address.
- disp_valid  out  1  disp_data valid.
- disp_data  out  DATA_W  read data; equals ram_rdata.
- wr_valid  in  1  writer has a write.
- wr_ready  out  1  FIFO can accept.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- vblank  in  1  vertical blank indicator (vc >= 480).
- ram_en  out  1  RAM access enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_wdata  out  DATA_W  RAM write data (registered).
- ram_rdata  in  DATA_W  RAM read data, one cycle after ram_en.
- q_level  out  clog2(Q_DEPTH)+1  FIFO occupancy.
- busy  out  1  1 when q_level != 0 or a write is on the RAM port.

Behaviour:
- Reset: all outputs forced to 0 on the next rising edge, except wr_ready=1.
  - FIFO emptied; queued writes are discarded.
  - Read pipeline flags cleared; no spurious disp_valid after reset, even with a read in flight.
- Per-cycle arbitration in cycle t, evaluated in this order:
  - GRANT_DISP: disp_req=1 → ram_en=1, ram_we=0, ram_addr=disp_addr in cycle t+1.
  - GRANT_WR: disp_req=0, FIFO non-empty, and (VBLANK_ONLY=0 or vblank=1) → pop the head; in t+1 ram_en=1, ram_we=1, ram_addr/ram_wdata = head entry.
  - IDLE: otherwise ram_en=0 and ram_we=0 in t+1; ram_addr and ram_wdata hold.
- Read latency: disp_req in cycle t → disp_valid=1 in t+2, disp_data=ram_rdata.
  - disp_valid is a 2-stage shift of GRANT_DISP.
  - Back-to-back requests give back-to-back valids at full throughput.
- Write FIFO:
  - wr_ready = !full, combinational from the occupancy register.
  - Push on wr_valid && wr_ready.
  - No bypass: an entry pushed in cycle t is poppable no earlier than t+1.
  - Simultaneous push and pop: q_level unchanged.
  - Full: wr_ready=0 and wr_valid is ignored; no data is lost.
  - Pointers wrap modulo Q_DEPTH.
- Writes commit in FIFO order. No read/write coherence is provided: a read issued before a pending write drains returns the old data.
- VBLANK_ONLY=1:
  - Writes never drain while vblank=0, even if disp_req=0 (horizontal blank).
  - A write popped in the last vblank cycle still completes in t+1.
- Starvation: the writer can be starved for the whole visible line. This is expected; horizontal blank (160 cycles/line) or vertical blank drains the FIFO.
- busy drops only after the final write's ram_we cycle.

Decomposition:
- Shared package: VRAM_ADDR_W, VRAM_DATA_W, a grant enum (GNT_IDLE, GNT_DISP, GNT_WR), and the 640x480 geometry constants (H_VISIBLE, V_VISIBLE) used by callers to build disp_addr and vblank.
- One sub-module: wr_fifo_sync.
  - Parameters: DEPTH, WIDTH = ADDR_W + DATA_W.
  - Synchronous reset; push/pop, full/empty and level outputs.
- The arbiter and the read pipeline stay in the top.

Test Plan:
- Reset mid-stream: 3 writes queued, disp_req=1 streaming, assert reset 1 cycle → next cycle q_level=0, ram_en=0, disp_valid=0 for 2 cycles, wr_ready=1.
- Read latency: disp_req=1 with addr 0x00010 at t, RAM model returns 0xA → ram_en=1, we=0, addr=0x00010 at t+1; disp_valid=1, disp_data=0xA at t+2.
- Priority: FIFO holds (0x00100, 0x3), disp_req=1 for 5 cycles → no ram_we during them; write appears on the port exactly one cycle after disp_req falls.
- Full: disp_req=1 continuously, push 5 writes with Q_DEPTH=4 → wr_ready=0 after the 4th; 5th held; after disp_req=0, RAM receives writes 1..5 in order on 5 consecutive cycles, and q_level returns to 0.
- Simultaneous push/pop: q_level=2, disp_req=0, wr_valid=1 → q_level stays 2 and one write per cycle reaches the RAM.
- VBLANK_ONLY=1: 2 writes queued, disp_req=0, vblank=0 for 20 cycles → no ram_we; vblank rises → writes at the next 2 cycles, then busy=0.
